sram_ctrl: RTL and testbench

- Request-side controller that sits directly upstream of the 10x4 SRAM macro and is the only block driving its we/address/write_in pins.
- Accepts single read/write requests over a valid/ready handshake and sequences the SRAM's one-cycle registered read.
- Returns a response (read data or write ack) over a second valid/ready handshake.
- Adds address range checking and a clear sequencer that zero-fills every location.

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_ctrl_if.sv | 30 +++
 rtl/sram_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Constants and controller state encoding shared by the SRAM macro instance
// and its request-side controller.
package sram_pkg;

  localparam int SRAM_DEPTH = 10;
  localparam int SRAM_AW    = 4;
  localparam int SRAM_DW    = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP,
    CLEAR
  } ctrl_state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and the
// SRAM controller (slave).
interface sram_ctrl_if
  import sram_pkg::*;
#(
  parameter int AW = SRAM_AW,
  parameter int DW = SRAM_DW
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sram_ctrl.sv
// Request-side controller for the SRAM macro: sequences single reads/writes
// through the macro's registered read, checks address range, and zero-fills.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int DEPTH = SRAM_DEPTH,
  parameter int AW    = SRAM_AW,
  parameter int DW    = SRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_ctrl_if.slave    bus,
  input  logic          clear_req,
  output logic          busy,
  output logic          mem_we,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_in,
  input  logic [DW-1:0] mem_data_out
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  ctrl_state_t   state, state_n;
  logic          clear_pend, clear_pend_n;
  logic [AW-1:0] clr_cnt, clr_cnt_n;
  logic          mem_we_n;
  logic [AW-1:0] mem_address_n;
  logic [DW-1:0] mem_write_in_n;
  logic          rsp_valid_q, rsp_valid_n;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_n;
  logic          rsp_err_q, rsp_err_n;

  assign bus.req_ready = (state == IDLE) && !clear_pend;
  assign busy          = (state != IDLE) || clear_pend;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      clear_pend   <= 1'b0;
      clr_cnt      <= '0;
      mem_we       <= 1'b0;
      mem_address  <= '0;
      mem_write_in <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state        <= state_n;
      clear_pend   <= clear_pend_n;
      clr_cnt      <= clr_cnt_n;
      mem_we       <= mem_we_n;
      mem_address  <= mem_address_n;
      mem_write_in <= mem_write_in_n;
      rsp_valid_q  <= rsp_valid_n;
      rsp_rdata_q  <= rsp_rdata_n;
      rsp_err_q    <= rsp_err_n;
    end
  end

  always_comb begin
    state_n        = state;
    clear_pend_n   = clear_pend | clear_req;
    clr_cnt_n      = clr_cnt;
    mem_we_n       = mem_we;
    mem_address_n  = mem_address;
    mem_write_in_n = mem_write_in;
    rsp_valid_n    = rsp_valid_q;
    rsp_rdata_n    = rsp_rdata_q;
    rsp_err_n      = rsp_err_q;

    case (state)
      IDLE: begin
        if (clear_pend) begin
          clr_cnt_n = '0;
          state_n   = CLEAR;
        end else if (bus.req_valid && bus.req_ready) begin
          if (bus.req_addr >= DEPTH_A) begin
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
            rsp_valid_n = 1'b1;
            state_n     = RESP;
          end else begin
            mem_address_n  = bus.req_addr;
            mem_write_in_n = bus.req_wdata;
            mem_we_n       = bus.req_we;
            state_n        = ACCESS;
          end
        end
      end

      // mem_we is only ever raised on entry for writes, so it doubles as the
      // read/write flag for the access in flight.
      ACCESS: begin
        mem_we_n = 1'b0;
        if (mem_we) begin
          rsp_rdata_n = '0;
          rsp_err_n   = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end else begin
          state_n = CAPTURE;
        end
      end

      CAPTURE: begin
        rsp_rdata_n = mem_data_out;
        rsp_err_n   = 1'b0;
        rsp_valid_n = 1'b1;
        state_n     = RESP;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end

      // Further clear requests during a pass are absorbed.
      CLEAR: begin
        clear_pend_n = clear_pend;
        if (clr_cnt == DEPTH_A) begin
          mem_we_n     = 1'b0;
          clear_pend_n = 1'b0;
          state_n      = IDLE;
        end else begin
          mem_we_n       = 1'b1;
          mem_address_n  = clr_cnt;
          mem_write_in_n = '0;
          clr_cnt_n      = clr_cnt + AW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: behavioural SRAM macro, array-based
// memory model, directed scenarios followed by randomized traffic.
module tb_sram_ctrl;
  import sram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear_req;
  logic       busy;
  logic       mem_we;
  logic [3:0] mem_address;
  logic [3:0] mem_write_in;
  logic [3:0] mem_data_out;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_mem [SRAM_DEPTH];
  logic [3:0] sram    [16];

  sram_ctrl_if #(.AW(SRAM_AW), .DW(SRAM_DW)) bus ();

  sram_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .clear_req    (clear_req),
    .busy         (busy),
    .mem_we       (mem_we),
    .mem_address  (mem_address),
    .mem_write_in (mem_write_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // SRAM macro: write on we, registered read of the presented address.
  always @(posedge clk) begin
    if (mem_we) sram[mem_address] <= mem_write_in;
    mem_data_out <= sram[mem_address];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request end to end; expectations come from the memory model and the
  // latency rules (out-of-range 1, write 2, read 3 edges counting the accept edge).
  task automatic apply_stimulus(input logic we, input logic [3:0] addr, input logic [3:0] wdata,
                                input int hold, input logic with_clear);
    int         n;
    int         lat;
    int         we_cnt;
    int         exp_lat;
    int         exp_we;
    logic       exp_err;
    logic [3:0] exp_rdata;

    exp_err   = (int'(addr) >= SRAM_DEPTH);
    exp_rdata = 4'h0;
    if (exp_err)  exp_lat = 1;
    else if (we)  exp_lat = 2;
    else          exp_lat = 3;
    if (!exp_err && !we) exp_rdata = exp_mem[addr];
    exp_we = (!exp_err && we) ? 1 : 0;

    n = 0;
    while (!bus.req_ready && n < 100) begin
      tick();
      n++;
    end
    check_output("req_ready_before_accept", bus.req_ready, 1);

    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    clear_req     = with_clear;
    tick();
    bus.req_valid = 1'b0;
    clear_req     = 1'b0;

    lat    = 1;
    we_cnt = 0;
    while (!bus.rsp_valid && lat < 10) begin
      we_cnt += int'(mem_we);
      tick();
      lat++;
    end
    check_output("rsp_latency", lat, exp_lat);
    check_output("rsp_rdata", bus.rsp_rdata, exp_rdata);
    check_output("rsp_err", bus.rsp_err, exp_err);
    check_output("mem_we_cycles", we_cnt, exp_we);
    if (!exp_err && we) exp_mem[addr] = wdata;

    for (int i = 0; i < hold; i++) begin
      tick();
      check_output("hold_rsp_valid", bus.rsp_valid, 1);
      check_output("hold_rsp_rdata", bus.rsp_rdata, exp_rdata);
      check_output("hold_req_ready", bus.req_ready, 0);
    end

    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_output("rsp_valid_after_handshake", bus.rsp_valid, 0);
    check_output("req_ready_after_handshake", bus.req_ready, !with_clear);
  endtask

  // Observes one zero-fill pass; optionally issues the clear pulse itself.
  task automatic run_clear(input logic pulse);
    int n;
    int we_cycles;
    int bad;

    if (pulse) begin
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
    end
    check_output("busy_clear_start", busy, 1);
    n = 0;
    we_cycles = 0;
    bad = 0;
    while (busy && n < 40) begin
      if (mem_we) begin
        if (mem_address !== 4'(we_cycles) || mem_write_in !== 4'h0) bad++;
        we_cycles++;
      end
      tick();
      n++;
    end
    check_output("clear_done", busy, 0);
    check_output("clear_we_cycles", we_cycles, SRAM_DEPTH);
    check_output("clear_bad_beats", bad, 0);
    check_output("clear_we_after", mem_we, 0);
    for (int a = 0; a < SRAM_DEPTH; a++) exp_mem[a] = 4'h0;
  endtask

  initial begin
    int seen;
    int r;
    logic w;

    rst_n         = 1'b0;
    clear_req     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'h0;
    bus.req_wdata = 4'h0;
    bus.rsp_ready = 1'b0;
    for (int a = 0; a < SRAM_DEPTH; a++) exp_mem[a] = 4'h0;

    repeat (3) tick();
    check_output("rst_req_ready", bus.req_ready, 1);
    check_output("rst_rsp_valid", bus.rsp_valid, 0);
    check_output("rst_rsp_rdata", bus.rsp_rdata, 0);
    check_output("rst_rsp_err", bus.rsp_err, 0);
    check_output("rst_mem_we", mem_we, 0);
    check_output("rst_mem_address", mem_address, 0);
    check_output("rst_mem_write_in", mem_write_in, 0);
    check_output("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] write then read back");
    apply_stimulus(1'b1, 4'd3, 4'hA, 0, 1'b0);
    apply_stimulus(1'b0, 4'd3, 4'h0, 0, 1'b0);

    $display("[TB] out-of-range read");
    apply_stimulus(1'b0, 4'd12, 4'h0, 0, 1'b0);
    apply_stimulus(1'b1, 4'd10, 4'h5, 0, 1'b0);
    apply_stimulus(1'b0, 4'd15, 4'h0, 1, 1'b0);

    $display("[TB] backpressure");
    apply_stimulus(1'b0, 4'd3, 4'h0, 5, 1'b0);

    $display("[TB] fill and clear");
    for (int a = 0; a < SRAM_DEPTH; a++) apply_stimulus(1'b1, 4'(a), 4'hF, 0, 1'b0);
    apply_stimulus(1'b0, 4'd9, 4'h0, 0, 1'b0);
    run_clear(1'b1);
    for (int a = 0; a < SRAM_DEPTH; a++) apply_stimulus(1'b0, 4'(a), 4'h0, 0, 1'b0);

    $display("[TB] clear colliding with accept");
    apply_stimulus(1'b1, 4'd5, 4'h7, 0, 1'b1);
    run_clear(1'b0);
    apply_stimulus(1'b0, 4'd5, 4'h0, 0, 1'b0);

    $display("[TB] reset during capture");
    apply_stimulus(1'b1, 4'd2, 4'h6, 0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'd2;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_output("midrst_rsp_valid", bus.rsp_valid, 0);
    check_output("midrst_mem_we", mem_we, 0);
    check_output("midrst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check_output("midrst_req_ready", bus.req_ready, 1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      seen += int'(bus.rsp_valid);
      tick();
    end
    check_output("midrst_no_response", seen, 0);
    apply_stimulus(1'b0, 4'd2, 4'h0, 0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 11));
      w = 1'($urandom_range(0, 1));
      if (r == 0) begin
        run_clear(1'b1);
      end else begin
        apply_stimulus(w, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 3)), r == 1);
        if (r == 1) run_clear(1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
